// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sequential accumulator for radix-4 Booth partial-product
// rows. Rows arrive least-significant first, one per valid/ready beat. Each row
// is weighted by 4^k. The finished 2*WIDTH-bit product is then offered on a
// valid/ready output.
module booth_pp_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pp_valid,
    output logic               pp_ready,
    input  logic [WIDTH:0]     pp_in,
    input  logic               p_in,
    input  logic               s_in,
    input  logic               abort,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    // One extra row beyond WIDTH/2 so that unsigned multipliers terminate
    // with a non-negative top digit.
    localparam int NROWS = WIDTH / 2 + 1;
    localparam int PW    = 2 * WIDTH;
    // The counter must also hold NROWS, which it reaches after the last beat.
    localparam int CW    = $clog2(NROWS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;

    logic [WIDTH+1:0] row_raw;
    logic [PW-1:0]    row_ext;
    logic [PW-1:0]    row_shifted;
    logic             pp_beat;
    logic             last_row;

    // The encoder drives an inverted sign bit. Restoring it gives a WIDTH+2-bit
    // two's-complement row. The negate flag completes the one's complement at
    // the row LSB, so it is added before the row is shifted into place.
    assign row_raw     = {~p_in, pp_in};
    assign row_ext     = {{(PW-WIDTH-2){row_raw[WIDTH+1]}}, row_raw} + PW'(s_in);
    assign row_shifted = row_ext << {cnt_q, 1'b0};

    assign pp_ready   = (state_q != DONE);
    assign prod_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign product    = acc_q;

    assign pp_beat  = pp_valid & pp_ready;
    assign last_row = (cnt_q == CW'(NROWS - 1));

    // Next-state logic. abort overrides any beat or handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pp_beat) begin
                        acc_d   = row_ext;
                        cnt_d   = CW'(1);
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (pp_beat) begin
                        acc_d = acc_q + row_shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (last_row) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (prod_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // State, row counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator at WIDTH=8 (5 rows per product).
module tb_booth_pp_accumulator;

    localparam int WIDTH = 8;
    localparam int NROWS = WIDTH / 2 + 1;

    logic               clk;
    logic               rst_n;
    logic               pp_valid;
    logic               pp_ready;
    logic [WIDTH:0]     pp_in;
    logic               p_in;
    logic               s_in;
    logic               abort;
    logic               prod_valid;
    logic               prod_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    booth_pp_accumulator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .pp_in      (pp_in),
        .p_in       (p_in),
        .s_in       (s_in),
        .abort      (abort),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [15:0] exp_q[$];
    logic [8:0]  row_pp[NROWS];
    logic        row_p[NROWS];
    logic        row_s[NROWS];

    bit gap_en     = 0;
    bit rand_ready = 0;
    int hold_cnt   = 0;

    logic        held;
    logic [15:0] held_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Golden radix-4 Booth encoder: produces the rows an upstream encoder
    // would send for a*b. Signed operands are sign-extended, unsigned ones
    // are zero-extended.
    task automatic booth_rows(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        logic [9:0] ext;
        int av, d, v, mag;
        int b2, b1, b0;
        ext = sgn ? {{2{b[7]}}, b} : {2'b00, b};
        av  = sgn ? int'($signed(a)) : int'(a);
        for (int k = 0; k < NROWS; k++) begin
            b2 = int'(ext[2*k+1]);
            b1 = int'(ext[2*k]);
            b0 = (k == 0) ? 0 : int'(ext[2*k-1]);
            d  = -2 * b2 + b1 + b0;
            v  = d * av;
            if (v < 0) begin
                mag       = -v;
                row_pp[k] = ~mag[8:0];
                row_p[k]  = 1'b0;
                row_s[k]  = 1'b1;
            end else begin
                row_pp[k] = v[8:0];
                row_p[k]  = 1'b1;
                row_s[k]  = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int r;
        if (sgn) r = int'($signed(a)) * int'($signed(b));
        else     r = int'(a) * int'(b);
        return r[15:0];
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (pp_ready) break;
            n++;
            if (n > 200) begin
                check_eq("pp_ready_timeout", {63'd0, pp_ready}, 64'd1);
                break;
            end
        end
    endtask

    // mode 0: normal product; 1: abort together with row 3; 2: async reset before row 2.
    task automatic send(input int mode, input logic [15:0] expv);
        if (mode == 0) exp_q.push_back(expv);
        for (int k = 0; k < NROWS; k++) begin
            if (gap_en) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (mode == 2 && k == 2) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_eq("rst_pp_ready",   {63'd0, pp_ready},   64'd1);
                check_eq("rst_prod_valid", {63'd0, prod_valid}, 64'd0);
                check_eq("rst_product",    {48'd0, product},    64'd0);
                check_eq("rst_busy",       {63'd0, busy},       64'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            pp_valid = 1'b1;
            pp_in    = row_pp[k];
            p_in     = row_p[k];
            s_in     = row_s[k];
            abort    = (mode == 1 && k == 3);
            wait_ready();
            @(posedge clk);
            #1;
            pp_valid = 1'b0;
            abort    = 1'b0;
            pp_in    = 9'($urandom);
            p_in     = 1'($urandom);
            s_in     = 1'($urandom);
            if (mode == 1 && k == 3) begin
                @(negedge clk);
                check_eq("abort_busy",       {63'd0, busy},       64'd0);
                check_eq("abort_prod_valid", {63'd0, prod_valid}, 64'd0);
                @(posedge clk);
                #1;
                return;
            end
        end
        @(negedge clk);
        check_eq("latency_prod_valid", {63'd0, prod_valid}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // prod_ready driver: optional forced-low window, otherwise always or randomly ready.
    initial begin
        prod_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                prod_ready = 1'b0;
                hold_cnt--;
            end else begin
                prod_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Output monitor: checks DONE-state invariants and pops the scoreboard on handshake.
    initial begin
        logic [15:0] e;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (prod_valid) begin
                    check_eq("pp_ready_in_done", {63'd0, pp_ready}, 64'd0);
                    if (held) check_eq("product_stable", {48'd0, product}, {48'd0, held_val});
                    if (prod_ready) begin
                        if (exp_q.size() == 0) begin
                            check_eq("unexpected_prod_valid", {63'd0, prod_valid}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            n_done++;
                            $display("product %0d: got %04h expected %04h", n_done, product, e);
                            check_eq("product", {48'd0, product}, {48'd0, e});
                        end
                    end
                end
                held     = prod_valid & ~prod_ready;
                held_val = product;
            end
        end
    end

    initial begin
        logic [7:0] a, b;
        bit sgn;
        int n;

        rst_n    = 1'b0;
        pp_valid = 1'b0;
        pp_in    = '0;
        p_in     = 1'b0;
        s_in     = 1'b0;
        abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_pp_ready",   {63'd0, pp_ready},   64'd1);
        check_eq("reset_prod_valid", {63'd0, prod_valid}, 64'd0);
        check_eq("reset_product",    {48'd0, product},    64'd0);
        check_eq("reset_busy",       {63'd0, busy},       64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero rows.
        for (int k = 0; k < NROWS; k++) begin
            row_pp[k] = 9'h000; row_p[k] = 1'b1; row_s[k] = 1'b0;
        end
        send(0, 16'h0000);

        // 1 + (-1 << 2).
        row_pp[1] = 9'h1FE; row_p[1] = 1'b0; row_s[1] = 1'b1;
        row_pp[0] = 9'h001;
        send(0, 16'hFFFD);

        booth_rows(8'hFF, 8'hFF, 1'b0); send(0, 16'hFE01);
        booth_rows(8'hFD, 8'h05, 1'b1); send(0, 16'hFFF1);
        booth_rows(8'h80, 8'h80, 1'b1); send(0, 16'h4000);

        // Downstream stalls for 10 cycles in DONE; the next product queues behind it.
        booth_rows(8'd100, 8'd37, 1'b0);
        hold_cnt = 5 + 10;
        send(0, ref_prod(8'd100, 8'd37, 1'b0));
        booth_rows(8'd200, 8'd3, 1'b0);
        send(0, ref_prod(8'd200, 8'd3, 1'b0));

        // Abort on row 3, then a clean 7*9.
        booth_rows(8'd55, 8'd66, 1'b0);
        send(1, 16'h0000);
        repeat (3) begin @(posedge clk); #1; end
        booth_rows(8'd7, 8'd9, 1'b0);
        send(0, 16'h003F);

        // Asynchronous reset mid-product, then a fresh product.
        booth_rows(8'd250, 8'd250, 1'b0);
        send(2, 16'h0000);
        booth_rows(8'd123, 8'd45, 1'b0);
        send(0, ref_prod(8'd123, 8'd45, 1'b0));

        // Random operands with gaps and random back-pressure.
        gap_en     = 1;
        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sgn = 1'($urandom);
            booth_rows(a, b, sgn);
            send(0, ref_prod(a, b, sgn));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
